// File: rtl/dmem_arb_pkg.sv
// Shared types and default widths for the data-memory arbiter.
package dmem_arb_pkg;
  localparam int ARB_AW       = 8;
  localparam int ARB_DW       = 8;
  localparam int ARB_LW       = 4;
  localparam int ARB_MAX_WAIT = 4;

  typedef enum logic {IDLE, HOST} arb_state_t;

  // Host burst descriptor, captured at grant time
  typedef struct packed {
    logic              we;
    logic [ARB_AW-1:0] addr;
    logic [ARB_LW-1:0] len;
  } burst_t;
endpackage

// File: rtl/dmem_arb_starve.sv
// Starvation limiter: counts cycles a pending host request loses to the core.
module dmem_arb_starve #(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic pending,
  input  logic served,
  input  logic clear,
  output logic force_grant
);
  localparam int CW = $clog2(MAX_WAIT) + 1;

  logic [CW-1:0] wait_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                   wait_cnt <= '0;
    else if (clear)                               wait_cnt <= '0;
    else if (served && wait_cnt != CW'(MAX_WAIT)) wait_cnt <= wait_cnt + CW'(1);
  end

  // After MAX_WAIT lost cycles the host wins on the following cycle
  assign force_grant = pending && (wait_cnt == CW'(MAX_WAIT));
endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter: core has priority, host bursts are starvation-limited.
// Optional perf counters (stall_cycles, host_bursts) under `DMEM_ARB_PERF_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW       = ARB_AW,
  parameter int DW       = ARB_DW,
  parameter int LW       = ARB_LW,
  parameter int MAX_WAIT = ARB_MAX_WAIT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic [DW-1:0] core_rdata,
  output logic          core_stall,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [LW-1:0] host_len,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic          host_beat,
  output logic          host_rvalid,
  output logic [DW-1:0] host_rdata,
  output logic          host_done,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [15:0]   stall_cycles,
  output logic [15:0]   host_bursts
`endif
);
  arb_state_t    state, state_nxt;
  burst_t        burst;
  logic [LW-1:0] beat_cnt;
  logic          in_idle, in_host, grant, force_grant, last_beat;

  // Gating with reset keeps every strobe low while reset is held, without a clock
  assign in_idle   = reset && (state == IDLE);
  assign in_host   = reset && (state == HOST);
  assign grant     = in_idle && host_req && (!core_req || force_grant);
  assign last_beat = in_host && (beat_cnt == burst.len - LW'(1));

  assign host_gnt   = grant;
  assign host_done  = last_beat;
  assign core_rdata = mem_rdata;

  dmem_arb_starve #(.MAX_WAIT(MAX_WAIT)) u_starve (
    .clk        (clk),
    .reset      (reset),
    .pending    (in_idle && host_req),
    .served     (in_idle && host_req && core_req),
    .clear      (!(in_idle && host_req) || grant),
    .force_grant(force_grant)
  );

  always_comb begin
    state_nxt  = state;
    mem_we     = in_idle & core_req & core_we;
    mem_addr   = core_addr;
    mem_wdata  = core_wdata;
    host_beat  = 1'b0;
    core_stall = 1'b0;
    case (state)
      IDLE: if (grant) state_nxt = HOST;
      HOST: begin
        mem_addr   = burst.addr + AW'(beat_cnt);
        mem_we     = in_host & burst.we;
        mem_wdata  = host_wdata;
        host_beat  = in_host;
        core_stall = in_host & core_req;
        if (last_beat) state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      burst       <= '0;
      beat_cnt    <= '0;
      host_rvalid <= 1'b0;
      host_rdata  <= '0;
    end else begin
      state       <= state_nxt;
      host_rvalid <= host_beat & ~burst.we;
      if (host_beat && !burst.we) host_rdata <= mem_rdata;
      if (grant) begin
        burst.we   <= host_we;
        burst.addr <= host_addr;
        burst.len  <= (host_len == '0) ? LW'(1) : host_len;
      end
      if (last_beat)      beat_cnt <= '0;
      else if (host_beat) beat_cnt <= beat_cnt + LW'(1);
    end
  end

`ifdef DMEM_ARB_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
      host_bursts  <= '0;
    end else begin
      if (core_stall && stall_cycles != 16'hFFFF) stall_cycles <= stall_cycles + 16'd1;
      if (host_done && host_bursts != 16'hFFFF)   host_bursts  <= host_bursts + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural single-port memory.
module tb_dmem_arbiter;
  logic       clk = 1'b0;
  logic       reset;
  logic       core_req, core_we, core_stall;
  logic [7:0] core_addr, core_wdata, core_rdata;
  logic       host_req, host_we, host_gnt, host_beat, host_rvalid, host_done;
  logic [7:0] host_addr, host_wdata, host_rdata;
  logic [3:0] host_len;
  logic       mem_we;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
`ifdef DMEM_ARB_PERF_EN
  logic [15:0] stall_cycles, host_bursts;
`endif

  typedef struct packed {logic we; logic [7:0] addr; logic [7:0] data;} beat_t;
  beat_t      beat_q[$];
  logic [7:0] rd_q[$];
  int n_cmp = 0, n_err = 0;
  logic [7:0] mem [256];

  dmem_arbiter dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_rdata(core_rdata), .core_stall(core_stall),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_len(host_len), .host_wdata(host_wdata), .host_gnt(host_gnt),
    .host_beat(host_beat), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .host_done(host_done), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_PERF_EN
    , .stall_cycles(stall_cycles), .host_bursts(host_bursts)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0;
    host_req = 0; host_we = 0; host_addr = 0; host_len = 0; host_wdata = 0;
  endtask

  task automatic test_reset();
    reset = 0; idle();
    core_req = 1; core_we = 1; host_req = 1;
    #3;
    n_cmp++; if (host_gnt !== 1'b0) begin n_err++; $display("FAIL reset_gnt: got %b want 0", host_gnt); end
    n_cmp++; if ({host_beat, host_rvalid, host_done, core_stall, mem_we} !== 5'b0) begin
      n_err++; $display("FAIL reset_strobes: got %b want 00000", {host_beat, host_rvalid, host_done, core_stall, mem_we});
    end
    n_cmp++; if (host_rdata !== 8'h00) begin n_err++; $display("FAIL reset_rdata: got %h want 00", host_rdata); end
    idle();
    repeat (2) @(posedge clk);
    #2 reset = 1;
    tick();
  endtask

  task automatic test_core_only();
    core_req = 1; core_we = 1; core_addr = 8'h10; core_wdata = 8'hA5; #1;
    n_cmp++; if ({mem_we, mem_addr, mem_wdata, core_stall} !== {1'b1, 8'h10, 8'hA5, 1'b0}) begin
      n_err++; $display("FAIL core_store: got we=%b a=%h d=%h stall=%b want 1 10 a5 0", mem_we, mem_addr, mem_wdata, core_stall);
    end
    tick(); core_we = 0; #1;
    n_cmp++; if ({core_rdata, mem_we, core_stall} !== {8'hA5, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL core_load: got rd=%h we=%b stall=%b want a5 0 0", core_rdata, mem_we, core_stall);
    end
    idle();
  endtask

  task automatic test_host_write();
    beat_t b; int beats = 0;
    tick(); host_req = 1; host_we = 1; host_addr = 8'h20; host_len = 4; #1;
    n_cmp++; if ({host_gnt, host_beat} !== 2'b10) begin n_err++; $display("FAIL wr_grant: got gnt=%b beat=%b want 1 0", host_gnt, host_beat); end
    for (int i = 0; i < 4; i++) begin b.we = 1; b.addr = 8'h20 + 8'(i); b.data = 8'(i + 1); beat_q.push_back(b); end
    tick(); host_req = 0; host_wdata = 8'd1;
    for (int k = 0; k < 10 && beat_q.size() != 0; k++) begin
      #1;
      n_cmp++; if (host_beat !== 1'b1) begin n_err++; $display("FAIL wr_beat_gap: cycle %0d got beat=%b want 1", k, host_beat); end
      if (host_beat === 1'b1) begin
        b = beat_q.pop_front();
        n_cmp++; if ({mem_we, mem_addr, mem_wdata} !== {b.we, b.addr, b.data}) begin
          n_err++; $display("FAIL wr_beat: got %b %h %h want %b %h %h", mem_we, mem_addr, mem_wdata, b.we, b.addr, b.data);
        end
        n_cmp++; if (host_done !== 1'(beat_q.size() == 0)) begin n_err++; $display("FAIL wr_done: got %b at beat %0d", host_done, beats); end
        beats++;
      end
      tick(); host_wdata = 8'(beats + 1);
    end
    n_cmp++; if (beat_q.size() != 0) begin n_err++; $display("FAIL wr_timeout: %0d beats left want 0", beat_q.size()); beat_q.delete(); end
    #1;
    n_cmp++; if (host_beat !== 1'b0) begin n_err++; $display("FAIL wr_after: got beat=%b want 0", host_beat); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (mem[8'h20 + i] !== 8'(i + 1)) begin n_err++; $display("FAIL wr_mem[%0d]: got %h want %h", i, mem[8'h20 + i], i + 1); end
    end
    idle();
  endtask

  task automatic test_len_zero();
    tick(); host_req = 1; host_we = 1; host_addr = 8'h50; host_len = 0; #1;
    n_cmp++; if (host_gnt !== 1'b1) begin n_err++; $display("FAIL len0_gnt: got %b want 1", host_gnt); end
    tick(); host_req = 0; host_wdata = 8'h77; #1;
    n_cmp++; if ({host_beat, host_done, mem_we, mem_addr} !== {3'b111, 8'h50}) begin
      n_err++; $display("FAIL len0_beat: got beat=%b done=%b we=%b a=%h want 1 1 1 50", host_beat, host_done, mem_we, mem_addr);
    end
    tick(); #1;
    n_cmp++; if (host_beat !== 1'b0 || mem[8'h50] !== 8'h77) begin
      n_err++; $display("FAIL len0_end: got beat=%b mem=%h want 0 77", host_beat, mem[8'h50]);
    end
    idle();
  endtask

  task automatic test_wrap_read();
    beat_t b; logic [7:0] exp;
    mem[8'hFE] = 8'h11; mem[8'hFF] = 8'h22; mem[8'h00] = 8'h33;
    tick(); host_req = 1; host_we = 0; host_addr = 8'hFE; host_len = 3; #1;
    n_cmp++; if (host_gnt !== 1'b1) begin n_err++; $display("FAIL rd_gnt: got %b want 1", host_gnt); end
    for (int i = 0; i < 3; i++) begin b.we = 0; b.addr = 8'hFE + 8'(i); b.data = 0; beat_q.push_back(b); end
    rd_q.push_back(8'h11); rd_q.push_back(8'h22); rd_q.push_back(8'h33);
    tick(); host_req = 0;
    for (int k = 0; k < 10 && (beat_q.size() != 0 || rd_q.size() != 0); k++) begin
      #1;
      if (host_beat === 1'b1 && beat_q.size() != 0) begin
        b = beat_q.pop_front();
        n_cmp++; if ({mem_we, mem_addr} !== {b.we, b.addr}) begin
          n_err++; $display("FAIL rd_beat: got we=%b a=%h want %b %h", mem_we, mem_addr, b.we, b.addr);
        end
      end
      if (host_rvalid === 1'b1) begin
        n_cmp++;
        if (rd_q.size() == 0) begin n_err++; $display("FAIL rd_spurious: rvalid with nothing expected"); end
        else begin
          exp = rd_q.pop_front();
          if (host_rdata !== exp) begin n_err++; $display("FAIL rd_data: got %h want %h", host_rdata, exp); end
        end
      end
      tick();
    end
    n_cmp++; if (beat_q.size() != 0 || rd_q.size() != 0) begin
      n_err++; $display("FAIL rd_timeout: beats left %0d reads left %0d want 0 0", beat_q.size(), rd_q.size());
      beat_q.delete(); rd_q.delete();
    end
    idle();
  endtask

  task automatic test_withdraw();
    int gnt_at = -1;
    tick(); core_req = 1; host_req = 1; host_we = 0; host_addr = 8'h00; host_len = 1;
    tick(); tick();
    host_req = 0; tick();
    host_req = 1;
    for (int k = 0; k < 12 && gnt_at < 0; k++) begin
      #1;
      if (host_gnt === 1'b1) gnt_at = k;
      else tick();
    end
    n_cmp++; if (gnt_at != 4) begin n_err++; $display("FAIL withdraw_gnt: got cycle %0d want 4", gnt_at); end
    tick(); host_req = 0; core_req = 0; #1;
    n_cmp++; if ({host_beat, host_done} !== 2'b11) begin n_err++; $display("FAIL withdraw_beat: got %b want 11", {host_beat, host_done}); end
    tick();
    idle();
  endtask

  task automatic test_starve();
    beat_t b; int gnt_at = -1; int beats = 0;
    tick(); reset = 0; #2 reset = 1;
    tick(); core_req = 1; core_we = 0; core_addr = 8'h05;
    host_req = 1; host_we = 1; host_addr = 8'h40; host_len = 4;
    for (int k = 0; k < 12 && gnt_at < 0; k++) begin
      #1;
      n_cmp++; if (core_stall !== 1'b0 || mem_addr !== 8'h05) begin
        n_err++; $display("FAIL starve_core: cycle %0d got stall=%b a=%h want 0 05", k, core_stall, mem_addr);
      end
      if (host_gnt === 1'b1) gnt_at = k;
      else tick();
    end
    n_cmp++; if (gnt_at != 4) begin n_err++; $display("FAIL starve_gnt: got cycle %0d want 4", gnt_at); end
    for (int i = 0; i < 4; i++) begin b.we = 1; b.addr = 8'h40 + 8'(i); b.data = 8'hB0 + 8'(i); beat_q.push_back(b); end
    tick(); host_req = 0; host_wdata = 8'hB0;
    for (int k = 0; k < 10 && beat_q.size() != 0; k++) begin
      #1;
      n_cmp++; if ({host_beat, core_stall} !== 2'b11) begin n_err++; $display("FAIL starve_stall: got beat=%b stall=%b want 1 1", host_beat, core_stall); end
      if (host_beat === 1'b1) begin
        b = beat_q.pop_front();
        n_cmp++; if ({mem_we, mem_addr, mem_wdata} !== {b.we, b.addr, b.data}) begin
          n_err++; $display("FAIL starve_beat: got %b %h %h want %b %h %h", mem_we, mem_addr, mem_wdata, b.we, b.addr, b.data);
        end
        beats++;
      end
      tick(); host_wdata = 8'hB0 + 8'(beats);
    end
    n_cmp++; if (beat_q.size() != 0) begin n_err++; $display("FAIL starve_timeout: %0d beats left want 0", beat_q.size()); beat_q.delete(); end
    #1;
    n_cmp++; if (core_stall !== 1'b0 || mem_addr !== 8'h05) begin
      n_err++; $display("FAIL starve_release: got stall=%b a=%h want 0 05", core_stall, mem_addr);
    end
`ifdef DMEM_ARB_PERF_EN
    n_cmp++; if (stall_cycles !== 16'd4) begin n_err++; $display("FAIL perf_stall: got %0d want 4", stall_cycles); end
    n_cmp++; if (host_bursts !== 16'd1) begin n_err++; $display("FAIL perf_bursts: got %0d want 1", host_bursts); end
`endif
    idle();
  endtask

  task automatic test_reset_mid();
    bit bad = 0;
    for (int i = 0; i < 4; i++) mem[8'h60 + i] = 8'h00;
    tick(); host_req = 1; host_we = 1; host_addr = 8'h60; host_len = 4;
    tick(); host_req = 0; host_wdata = 8'hA1;
    tick(); host_wdata = 8'hA2;
    tick(); host_wdata = 8'hA3;
    #2 reset = 0; #1;
    n_cmp++; if ({host_beat, mem_we, host_done, host_gnt, core_stall, host_rvalid} !== 6'b0) begin
      n_err++; $display("FAIL rstmid_async: got %b want 000000", {host_beat, mem_we, host_done, host_gnt, core_stall, host_rvalid});
    end
    tick(); tick(); reset = 1; host_wdata = 8'hA4;
    for (int k = 0; k < 5; k++) begin
      #1; if (host_beat !== 1'b0 || host_done !== 1'b0) bad = 1;
      tick();
    end
    n_cmp++; if (bad) begin n_err++; $display("FAIL rstmid_resume: burst continued after reset"); end
    n_cmp++; if ({mem[8'h60], mem[8'h61], mem[8'h62], mem[8'h63]} !== 32'hA1A2_0000) begin
      n_err++; $display("FAIL rstmid_mem: got %h%h%h%h want a1a20000", mem[8'h60], mem[8'h61], mem[8'h62], mem[8'h63]);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    test_reset();
    test_core_only();
    test_host_write();
    test_len_zero();
    test_wrap_read();
    test_withdraw();
    test_starve();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-port data memory (dat_mem) between the core datapath (lw/sw path) and a host loader/DMA port that bursts data in or out.
- Core has default priority; host bursts are granted by a starvation limiter and are non-interruptible once started.
- core_stall freezes the PC and register writes while the core is blocked.
- Sits between the top-level datapath, the memory and the test harness.

Parameters:
AW, 8, address width (matches 8-bit datA addressing)
DW, 8, data width
LW, 4, burst length field width (1..2^LW-1 beats)
MAX_WAIT, 4, consecutive core-priority cycles a pending host request tolerates before forced grant

Ports:
clk  in  1  clock, all state updates on posedge
reset  in  1  asynchronous, active-low reset
core_req  in  1  core memory access this cycle (load or store)
core_we  in  1  1=store, 0=load
core_addr  in  AW  core address
core_wdata  in  DW  core store data
core_rdata  out  DW  load data, combinational from mem_rdata
core_stall  out  1  core access not performed this cycle; hold PC
host_req  in  1  host burst request, level, held until host_gnt
host_we  in  1  burst direction, sampled at grant
host_addr  in  AW  burst start address, sampled at grant
host_len  in  LW  beats, sampled at grant; 0 treated as 1
host_wdata  in  DW  write data for current beat
host_gnt  out  1  one-cycle pulse, burst accepted
host_beat  out  1  a host beat hits memory this cycle; host advances host_wdata next cycle
host_rvalid  out  1  registered; host_rdata valid
host_rdata  out  DW  registered read data of previous beat
host_done  out  1  one-cycle pulse with final beat
mem_we  out  1  to dat_mem wr_en
mem_addr  out  AW  to dat_mem addr
mem_wdata  out  DW  to dat_mem dat_in
mem_rdata  in  DW  from dat_mem dat_out (combinational read)

Behaviour:
- Reset (reset=0, async) state=IDLE. Outputs: host_gnt=0, host_beat=0, host_rvalid=0, host_rdata=0, host_done=0, core_stall=0, mem_we=0. Internal wait_cnt=0, beat_cnt=0.
- IDLE (core owns memory):
  - mem_* driven from core_*; mem_we=core_req&core_we.
  - Core access completes in the same cycle with zero latency.
- Host arbitration in IDLE:
  - host_req & !core_req -> grant immediately.
  - host_req & core_req -> core served; wait_cnt++.
  - wait_cnt==MAX_WAIT-1 with host_req still pending -> grant on the next cycle regardless of core_req.
- Grant: host_gnt=1 for one cycle; latch we/addr/len; wait_cnt<=0; go to HOST. The grant cycle performs no host beat; the core is still served.
- HOST state:
  - Each cycle: host_beat=1, mem_addr=start+beat_cnt (mod 2^AW wrap), mem_we=latched_we, mem_wdata=host_wdata.
  - Read bursts: host_rdata<=mem_rdata and host_rvalid<=1 on the following cycle.
  - core_stall=core_req; core is never served during HOST.
  - Final beat (beat_cnt==len-1): host_done=1; next state IDLE; beat_cnt<=0.
  - host_req is ignored until back in IDLE. Back-to-back bursts need one IDLE cycle (re-grant).
- Core stores are never dropped: a stalled core holds core_* stable; the arbiter keeps no copy.
- host_req deasserted before grant: request withdrawn; wait_cnt<=0.
- Reset mid-burst: burst aborted, no host_done, memory contents up to the last completed beat retained.
- Width rules: address wrap is modulo 2^AW. beat_cnt is LW bits. wait_cnt is $clog2(MAX_WAIT)+1 bits.

Optional Feature:
DMEM_ARB_PERF_EN
- Defined: adds outputs stall_cycles[15:0] and host_bursts[15:0], both saturating counters cleared by reset.
  - stall_cycles increments every cycle core_stall=1.
  - host_bursts increments on host_done.
- Undefined: ports and logic absent; timing and function otherwise identical.

Decomposition:
- Package dmem_arb_pkg: typedef enum logic {IDLE, HOST} arb_state_t; default AW/DW/LW/MAX_WAIT localparams; the burst descriptor struct {we, addr, len}.
- One sub-module, dmem_arb_starve: the wait_cnt counter with inputs pending/served/clear and output force_grant.

Test Plan:
- Core-only: sw r? to addr 0x10 data 0xA5, then lw 0x10 -> mem_we one cycle, core_rdata=0xA5 same cycle, core_stall never 1.
- Host write burst, core idle: addr 0x20, len 4, data 1..4 -> host_gnt in cycle 1, beats cycles 2-5 at 0x20-0x23, host_done in cycle 5, memory holds 1,2,3,4.
- Starvation: core_req held high, host_req asserted with MAX_WAIT=4 -> host_gnt exactly 4 cycles later; core_stall=1 during every beat.
- Wrap + read: host read at addr 0xFE, len 3 (preloaded 0x11,0x22,0x33 at 0xFE,0xFF,0x00) -> host_rdata 0x11,0x22,0x33 on rvalid cycles, addresses wrap to 0x00.
- Async reset asserted mid-burst (after beat 2 of 4) -> outputs zero immediately without clock; beats 3-4 never written; host_done never pulses.
- With DMEM_ARB_PERF_EN: the starvation scenario gives stall_cycles=4 and host_bursts=1.
